// File: rtl/mem_bus_pkg.sv
// Shared encodings for the multi-bank memory bus controller: access sizes,
// fault codes, controller states and the default bank map.
package mem_bus_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  localparam logic [1:0] FLT_NONE    = 2'd0;
  localparam logic [1:0] FLT_ADDR    = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT = 2'd2;

  // Bank 0 sits in the low word: data RAM, I/O, VGA text RAM.
  localparam logic [95:0] DEFAULT_BANK_BASE = {32'h0000B800, 32'h7FFF0000, 32'h10010000};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/mem_lane_codec.sv
// Little-endian byte-lane codec: store lane placement/enables and load
// lane extraction with sign or zero extension. Purely combinational.
module mem_lane_codec
  import mem_bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        zext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = rword_i[{off_i, 3'b000} +: 8];
  assign half_s = off_i[1] ? rword_i[31:16] : rword_i[15:0];

  // Lane encode for stores and lane extract/extend for loads.
  always_comb begin
    be_o         = 4'b0000;
    lane_wdata_o = 32'h0000_0000;
    load_data_o  = 32'h0000_0000;
    case (size_i)
      SZ_WORD: begin
        be_o         = 4'b1111;
        lane_wdata_o = wdata_i;
        load_data_o  = rword_i;
      end
      SZ_HALF: begin
        be_o         = off_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_o = off_i[1] ? {wdata_i[15:0], 16'h0000} : {16'h0000, wdata_i[15:0]};
        load_data_o  = {{16{~zext_i & half_s[15]}}, half_s};
      end
      SZ_BYTE: begin
        be_o         = 4'b0001 << off_i;
        lane_wdata_o = {24'h00_0000, wdata_i[7:0]} << {off_i, 3'b000};
        load_data_o  = {{24{~zext_i & byte_s[7]}}, byte_s};
      end
      default: begin
        be_o         = 4'b0000;
        lane_wdata_o = 32'h0000_0000;
        load_data_o  = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Request/acknowledge bus controller between the core and its memory-mapped
// banks; stalls the core per access and latches sticky address/timeout faults.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                       NUM_BANKS = 3,
  parameter int                       BANK_BITS = 13,
  parameter logic [32*NUM_BANKS-1:0]  BANK_BASE = DEFAULT_BANK_BASE,
  parameter int                       TIMEOUT   = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_re,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [1:0]                cpu_size,
  input  logic                      cpu_zext,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_stall,
  output logic [1:0]                cpu_fault,
  output logic [NUM_BANKS-1:0]      bank_req,
  output logic [3:0]                bank_we,
  output logic [BANK_BITS-3:0]      bank_addr,
  output logic [31:0]               bank_wdata,
  input  logic [32*NUM_BANKS-1:0]   bank_rdata,
  input  logic [NUM_BANKS-1:0]      bank_ack
);

  localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, hit_idx_s;
  logic [NUM_BANKS-1:0] match_s;
  logic                 hit_s, access_s, bad_s, accept_s, ack_sel_s;
  logic                 load_q, zext_q;
  logic [1:0]           size_q, off_q, fault_q, fault_d;
  logic [1:0]           codec_size_s, codec_off_s;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d, bank_wdata_q, lane_wdata_s, load_data_s, rword_s;
  logic [3:0]           bank_we_q, be_s;
  logic [BANK_BITS-3:0] bank_addr_q;

  // Address decode; the lowest matching bank index wins.
  always_comb begin
    match_s   = '0;
    hit_idx_s = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      match_s[i] = (cpu_addr[31:BANK_BITS] == BANK_BASE[32*i+BANK_BITS +: 32-BANK_BITS]);
    end
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      hit_idx_s = match_s[i] ? IDX_W'(i) : hit_idx_s;
    end
  end

  assign hit_s    = |match_s;
  assign access_s = cpu_re | cpu_we;
  assign bad_s    = ~hit_s | (cpu_re & cpu_we) | (cpu_size == 2'd3)
                  | ((cpu_size == SZ_HALF) & cpu_addr[0])
                  | ((cpu_size == SZ_WORD) & (cpu_addr[1:0] != 2'b00));

  // One codec serves both directions: live CPU fields while idle, latched ones afterwards.
  assign codec_size_s = (state_q == ST_IDLE) ? cpu_size : size_q;
  assign codec_off_s  = (state_q == ST_IDLE) ? cpu_addr[1:0] : off_q;
  assign rword_s      = bank_rdata[32*idx_q +: 32];
  assign ack_sel_s    = bank_ack[idx_q];

  mem_lane_codec u_codec (
    .size_i       (codec_size_s),
    .off_i        (codec_off_s),
    .zext_i       (zext_q),
    .wdata_i      (cpu_wdata),
    .rword_i      (rword_s),
    .be_o         (be_s),
    .lane_wdata_o (lane_wdata_s),
    .load_data_o  (load_data_s)
  );

  // Next-state logic, wait counter, sticky fault and load capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    rdata_d  = rdata_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s && bad_s) begin
          state_d = ST_FAULT;
          fault_d = FLT_ADDR;
        end else if (access_s) begin
          state_d  = ST_ISSUE;
          accept_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        if (ack_sel_s) begin
          state_d = ST_DONE;
          rdata_d = load_q ? load_data_s : rdata_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // An ack on the final counted cycle still wins over the timeout.
        if (ack_sel_s) begin
          state_d = ST_DONE;
          rdata_d = load_q ? load_data_s : rdata_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_FAULT;
          fault_d = FLT_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and access-latch registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fault_q      <= FLT_NONE;
      rdata_q      <= 32'h0000_0000;
      idx_q        <= '0;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      zext_q       <= 1'b0;
      load_q       <= 1'b0;
      bank_we_q    <= 4'b0000;
      bank_addr_q  <= '0;
      bank_wdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (accept_s) begin
        idx_q        <= hit_idx_s;
        size_q       <= cpu_size;
        off_q        <= cpu_addr[1:0];
        zext_q       <= cpu_zext;
        load_q       <= cpu_re;
        bank_we_q    <= cpu_we ? be_s : 4'b0000;
        bank_addr_q  <= cpu_addr[BANK_BITS-1:2];
        bank_wdata_q <= lane_wdata_s;
      end
    end
  end

  assign cpu_stall  = ((state_q == ST_IDLE) & access_s) | (state_q == ST_ISSUE)
                    | (state_q == ST_WAIT) | (state_q == ST_FAULT);
  assign bank_req   = (state_q == ST_ISSUE) ? (NUM_BANKS'(1) << idx_q) : '0;
  assign cpu_fault  = fault_q;
  assign cpu_rdata  = rdata_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vector table, hand-written
// timeout/reset sequences and randomized accesses against a byte-level model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_re, cpu_we, cpu_zext;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size, cpu_fault;
  logic        cpu_stall;
  logic [2:0]  bank_req, bank_ack;
  logic [3:0]  bank_we;
  logic [10:0] bank_addr;
  logic [31:0] bank_wdata;
  logic [95:0] bank_rdata;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_zext(cpu_zext),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
    .bank_req(bank_req), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .bank_ack(bank_ack)
  );

  typedef struct {
    logic        re, we;
    logic [31:0] addr, wdata;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] word;
    int          lat;
    logic [1:0]  flt;
    logic [2:0]  req;
    logic [10:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwd, rd;
    int          stalls;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] base_tab [3] = '{32'h10010000, 32'h7FFF0000, 32'h0000B800};
  vec_t tab [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic re, logic we, logic [31:0] addr, logic [31:0] wdata,
                              logic [1:0] size, logic zext, logic [31:0] word, int lat,
                              logic [1:0] flt, logic [2:0] req, logic [10:0] baddr,
                              logic [3:0] be, logic [31:0] bwd, logic [31:0] rd, int stalls);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.zext = zext;
    v.word = word; v.lat = lat; v.flt = flt; v.req = req; v.baddr = baddr; v.be = be;
    v.bwd = bwd; v.rd = rd; v.stalls = stalls;
    return v;
  endfunction

  // Reference: decode, alignment and lane arithmetic computed on whole bytes.
  function automatic vec_t model(vec_t v);
    int hit = -1;
    int nb;
    logic [31:0] m;
    for (int i = 0; i < 3; i++)
      if (hit < 0 && v.addr[31:13] == base_tab[i][31:13]) hit = i;
    nb = (v.size == 2'd0) ? 4 : (v.size == 2'd1) ? 2 : 1;
    v.flt = 2'd0; v.req = 3'b000; v.baddr = 11'd0; v.be = 4'b0000;
    v.bwd = 32'd0; v.rd = 32'd0; v.stalls = 0;
    if (hit < 0 || (v.re && v.we) || v.size == 2'd3 || (int'(v.addr[1:0]) % nb) != 0) begin
      v.flt = 2'd1;
      return v;
    end
    v.req    = 3'b001 << hit;
    v.baddr  = v.addr[12:2];
    m        = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    v.stalls = 2 + v.lat;
    if (v.we) begin
      v.be  = 4'((1 << nb) - 1) << v.addr[1:0];
      v.bwd = (v.wdata & m) << (8 * int'(v.addr[1:0]));
    end
    if (v.re) begin
      v.rd = (v.word >> (8 * int'(v.addr[1:0]))) & m;
      if (!v.zext && nb < 4 && v.rd[8*nb-1]) v.rd = v.rd | ~m;
    end
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0; bank_ack = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drives one access from IDLE (just after a posedge) and checks it end to end.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls = 0;
    int reqs = 0;
    int k = -1;
    bit done = 1'b0;
    logic [31:0] m;
    for (int i = 0; i < 3; i++) bank_rdata[32*i +: 32] = v.req[i] ? v.word : $urandom;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{v.be[b]}};
    cpu_re = v.re; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_size = v.size; cpu_zext = v.zext;
    if (v.flt != 2'd0) begin
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (cpu_stall) stalls++;
        if (bank_req != 3'b000) reqs++;
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
      end
      check({tag, " fault"}, 32'(cpu_fault), 32'(v.flt));
      check({tag, " stall"}, 32'(stalls), 32'd6);
      check({tag, " reqs"}, 32'(reqs), 32'd0);
      do_reset();
      return;
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cpu_stall) stalls++;
      if (bank_req != 3'b000) begin
        reqs++;
        k = 0;
        check({tag, " req"}, 32'(bank_req), 32'(v.req));
        check({tag, " baddr"}, 32'(bank_addr), 32'(v.baddr));
        check({tag, " we"}, 32'(bank_we), 32'(v.be));
        if (v.we) check({tag, " wdata"}, bank_wdata & m, v.bwd & m);
      end else if (k >= 0) begin
        k++;
      end
      if (k == v.lat) begin
        bank_ack = v.req;
        if (v.lat > 0) begin
          check({tag, " baddr hold"}, 32'(bank_addr), 32'(v.baddr));
          check({tag, " we hold"}, 32'(bank_we), 32'(v.be));
        end
      end
      if (!cpu_stall) begin
        done = 1'b1;
        if (v.re) check({tag, " rdata"}, cpu_rdata, v.rd);
        check({tag, " nofault"}, 32'(cpu_fault), 32'd0);
        cpu_re = 1'b0; cpu_we = 1'b0;
      end
      @(posedge clk); #1;
      bank_ack = 3'b000;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL %s: access did not complete within 40 cycles", tag);
      do_reset();
    end else begin
      check({tag, " stall cycles"}, 32'(stalls), 32'(v.stalls));
      check({tag, " req count"}, 32'(reqs), 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    int first_flt;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    cpu_size = 2'd0; cpu_zext = 1'b0; bank_ack = 3'b000; bank_rdata = 96'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst stall", 32'(cpu_stall), 32'd0);
    check("rst fault", 32'(cpu_fault), 32'd0);
    check("rst rdata", cpu_rdata, 32'd0);
    check("rst req", 32'(bank_req), 32'd0);
    check("rst we", 32'(bank_we), 32'd0);
    check("rst baddr", 32'(bank_addr), 32'd0);
    check("rst wdata", bank_wdata, 32'd0);
    @(posedge clk); #1;

    tab[0]  = mk(1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 2'd0, 1'b0, 32'h0, 0,
                 2'd0, 3'b001, 11'd1, 4'b1111, 32'hDEADBEEF, 32'h0, 2);
    tab[1]  = mk(1'b1, 1'b0, 32'h10010003, 32'h0, 2'd2, 1'b0, 32'h80FF1234, 1,
                 2'd0, 3'b001, 11'd0, 4'b0000, 32'h0, 32'hFFFFFF80, 3);
    tab[2]  = mk(1'b1, 1'b0, 32'h10010003, 32'h0, 2'd2, 1'b1, 32'h80FF1234, 0,
                 2'd0, 3'b001, 11'd0, 4'b0000, 32'h0, 32'h00000080, 2);
    tab[3]  = mk(1'b0, 1'b1, 32'h0000B802, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, 4,
                 2'd0, 3'b100, 11'h600, 4'b1100, 32'hABCD0000, 32'h0, 6);
    tab[4]  = mk(1'b1, 1'b0, 32'h00000000, 32'h0, 2'd0, 1'b0, 32'h0, 0,
                 2'd1, 3'b000, 11'd0, 4'b0000, 32'h0, 32'h0, 0);
    tab[5]  = mk(1'b1, 1'b0, 32'h10010002, 32'h0, 2'd0, 1'b0, 32'h0, 0,
                 2'd1, 3'b000, 11'd0, 4'b0000, 32'h0, 32'h0, 0);
    tab[6]  = mk(1'b1, 1'b0, 32'h7FFF0010, 32'h0, 2'd0, 1'b0, 32'h12345678, 15,
                 2'd0, 3'b010, 11'd4, 4'b0000, 32'h0, 32'h12345678, 17);
    tab[7]  = mk(1'b1, 1'b0, 32'h7FFF1FFE, 32'h0, 2'd1, 1'b0, 32'h80017FFF, 2,
                 2'd0, 3'b010, 11'h7FF, 4'b0000, 32'h0, 32'hFFFF8001, 4);
    tab[8]  = mk(1'b1, 1'b0, 32'h10010000, 32'h0, 2'd3, 1'b0, 32'h0, 0,
                 2'd1, 3'b000, 11'd0, 4'b0000, 32'h0, 32'h0, 0);
    tab[9]  = mk(1'b1, 1'b1, 32'h10010000, 32'h0, 2'd0, 1'b0, 32'h0, 0,
                 2'd1, 3'b000, 11'd0, 4'b0000, 32'h0, 32'h0, 0);
    tab[10] = mk(1'b0, 1'b1, 32'h10010001, 32'h000000A5, 2'd2, 1'b0, 32'h0, 3,
                 2'd0, 3'b001, 11'd0, 4'b0010, 32'h0000A500, 32'h0, 5);
    tab[11] = mk(1'b1, 1'b0, 32'h10010000, 32'h0, 2'd1, 1'b1, 32'h1234F00D, 0,
                 2'd0, 3'b001, 11'd0, 4'b0000, 32'h0, 32'h0000F00D, 2);
    for (int i = 0; i < 12; i++) run_vec(tab[i], $sformatf("vec%0d", i));

    // Bank 0 never acks while bank 1 acks spuriously throughout WAIT.
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10010000; cpu_size = 2'd0;
    first_flt = -1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (first_flt < 0 && cpu_fault != 2'd0) begin
        first_flt = c;
        check("timeout code", 32'(cpu_fault), 32'd2);
      end
      bank_ack = (c >= 2 && c <= 16) ? 3'b010 : 3'b000;
      @(posedge clk); #1;
      bank_ack = 3'b000;
      cpu_re = 1'b0;
    end
    check("timeout cycle", 32'(first_flt), 32'd17);
    @(negedge clk);
    check("timeout stall", 32'(cpu_stall), 32'd1);
    check("timeout req", 32'(bank_req), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Reset in the middle of WAIT, then a late ack.
    bank_rdata = {32'h0, 32'h0, 32'h5A5A5A5A};
    cpu_re = 1'b1; cpu_addr = 32'h10010008; cpu_size = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; cpu_re = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid rst stall", 32'(cpu_stall), 32'd0);
    check("mid rst req", 32'(bank_req), 32'd0);
    check("mid rst fault", 32'(cpu_fault), 32'd0);
    check("mid rst rdata", cpu_rdata, 32'd0);
    check("mid rst we", 32'(bank_we), 32'd0);
    check("mid rst baddr", 32'(bank_addr), 32'd0);
    check("mid rst wdata", bank_wdata, 32'd0);
    bank_ack = 3'b001;
    @(posedge clk); #1 bank_ack = 3'b000;
    @(negedge clk);
    check("late ack stall", 32'(cpu_stall), 32'd0);
    check("late ack rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;
    v = mk(1'b1, 1'b0, 32'h10010008, 32'h0, 2'd0, 1'b0, 32'hCAFEF00D, 2,
           2'd0, 3'b000, 11'd0, 4'b0000, 32'h0, 32'h0, 0);
    run_vec(model(v), "post rst");

    for (int n = 0; n < 40; n++) begin
      int b;
      b = int'($urandom_range(0, 3));
      v.addr  = (b < 3) ? {base_tab[b][31:13], 13'($urandom)} : $urandom;
      case ($urandom_range(0, 9))
        0:             begin v.re = 1'b1; v.we = 1'b1; end
        1, 2, 3, 4, 5: begin v.re = 1'b1; v.we = 1'b0; end
        default:       begin v.re = 1'b0; v.we = 1'b1; end
      endcase
      v.size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (v.size == 2'd0) v.addr[1:0] = 2'b00;
        if (v.size == 2'd1) v.addr[0] = 1'b0;
      end
      v.zext  = 1'($urandom);
      v.wdata = $urandom;
      v.word  = $urandom;
      v.lat   = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
      run_vec(model(v), $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised multi-bank memory bus controller between the MIPS32 core and its memory-mapped banks (data RAM, VGA text RAM, I/O). Replaces the single-cycle decoder/encoder path with a request/acknowledge protocol, so banks may take several cycles. The core is stalled until the access completes. Address faults and bank timeouts latch as sticky faults that halt the core.

## Interface
- NUM_BANKS, 3: number of bank ports (1..8).
- BANK_BITS, 13: byte-address bits inside each bank; bank_addr width is BANK_BITS-2.
- BANK_BASE, {32'h0000B800, 32'h7FFF0000, 32'h10010000}: NUM_BANKS×32 flattened base addresses, bank 0 in the low word; each base has its low BANK_BITS bits zero.
- TIMEOUT, 15: maximum wait cycles for bank_ack before a timeout fault.
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cpu_re  in  1  load request
- cpu_we  in  1  store request
- cpu_addr  in  32  virtual byte address
- cpu_wdata  in  32  store data, right-aligned
- cpu_size  in  2  0 word, 1 half, 2 byte; 3 is illegal
- cpu_zext  in  1  loads: 1 zero-extend, 0 sign-extend
- cpu_rdata  out  32  extended load data, valid in DONE
- cpu_stall  out  1  core must hold PC and instruction
- cpu_fault  out  2  sticky: 0 none, 1 bad address/alignment/op, 2 timeout
- bank_req  out  NUM_BANKS  one-hot, single-cycle request
- bank_we  out  4  byte-lane write enables, 0 for loads
- bank_addr  out  BANK_BITS-2  word address inside bank
- bank_wdata  out  32  lane-aligned store data
- bank_rdata  in  NUM_BANKS×32  per-bank read words, flattened
- bank_ack  in  NUM_BANKS  per-bank completion

## Operation
- States: IDLE, ISSUE, WAIT, DONE, FAULT.
- IDLE, access = cpu_re|cpu_we. Decode bank i: cpu_addr[31:BANK_BITS] == BANK_BASE[i][31:BANK_BITS]. The lowest matching index wins.
- Fault checks, giving code 1 and FAULT: no bank hit; cpu_re&cpu_we; cpu_size==3; half access with addr[0]=1; word access with addr[1:0]≠0. Otherwise latch bank index, word address, offset, size, zext, byte enables and data, then go to ISSUE.
- Write lanes are little-endian, with byte k at bits 8k+7:8k.
  - word: be 1111.
  - half: be 0011 or 1100 by addr[1], data shifted 16×addr[1].
  - byte: be 1<<addr[1:0], data shifted 8×addr[1:0].
- ISSUE: bank_req[i]=1 for this cycle only. The WAIT counter is cleared.
- Ack in ISSUE goes to DONE. Otherwise go to WAIT.
- WAIT: bank_req=0.
  - bank_ack[i] goes to DONE.
  - A counter reaching TIMEOUT with no ack gives fault code 2 and FAULT.
  - Acks from unselected banks are ignored.
- Read data is captured from bank_rdata[i] on the ack cycle.
- Load extraction:
  - Select the byte or half lane by the latched offset.
  - Extend per zext; a word passes through.
  - The result is registered into cpu_rdata.
- DONE: stall=0 for one cycle, cpu_rdata valid, then IDLE. Acks arriving in IDLE or DONE are ignored.
- FAULT: absorbing until rst. stall=1, bank_req=0.

## Timing
- Reset values: state IDLE, cpu_stall 0, cpu_fault 0, cpu_rdata 0, bank_req 0, bank_we 0, bank_addr 0, bank_wdata 0.
- cpu_stall is combinational: (IDLE & access) | ISSUE | WAIT | FAULT.
- A zero-wait bank (ack in ISSUE) takes 3 cycles per access: IDLE → ISSUE → DONE. Stall is high for 2 of them.
- A bank acking n cycles after req adds n cycles.
- bank_we, bank_addr and bank_wdata are registered and stable from ISSUE through the ack cycle.
- rst asserted mid-access returns to IDLE on the next edge. bank_req drops immediately after that edge and the fault is cleared. A later ack is ignored.
- A timeout ack arriving on the same cycle the counter hits TIMEOUT is accepted; the ack has priority.

## Structure
- Package mem_bus_pkg holds:
  - size encodings (SZ_WORD/SZ_HALF/SZ_BYTE);
  - the state enum;
  - fault codes (FLT_NONE/FLT_ADDR/FLT_TIMEOUT);
  - the default bank base constants.
- Sub-module mem_lane_codec, purely combinational, holds the store lane encoding and the load extraction/extension. It is instantiated once and shared by the write and read paths.

## Test plan
- Zero-wait word store at 0x10010004, data 0xDEADBEEF, bank 0 acks in ISSUE. Require bank_req=001, bank_addr=1, bank_we=1111, stall high exactly 2 cycles.
- Byte load, signed, at 0x10010003, bank word 0x80FF1234. Require cpu_rdata=0xFFFFFF80; the same access with zext=1 gives 0x00000080.
- Half store at 0x0000B802, data 0x0000ABCD, bank 2 acks after 4 cycles. Require bank_we=1100, bank_wdata[31:16]=0xABCD, stall high 6 cycles.
- Load at 0x00000000 (no bank) and word load at 0x10010002. Each requires cpu_fault=1 sticky, no bank_req, stall held until rst.
- Bank never acks, TIMEOUT=15. Require cpu_fault=2 after 15 WAIT cycles, and a spurious ack from another bank during WAIT ignored.
- rst asserted during WAIT, then a late ack. Require IDLE, all outputs at reset values, ack ignored, the next access proceeding normally.
